gcd_control: RTL and testbench

- Control FSM for the subtractive GCD datapath; sits directly upstream of it and drives its x_sel, y_sel, x_en, y_en and output_en inputs.
- Consumes the datapath comparator flags x_lt_y and x_ne_y.
- Provides a start/done handshake to the surrounding system.
- Bounds runtime with an iteration limit so degenerate operands (a zero operand) terminate with an error instead of hanging.

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_control_if.sv | 28 ++
 rtl/gcd_iter_counter.sv | 27 ++
 rtl/gcd_control.sv | 103 ++++++++++
 tb/tb_gcd_control.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
package gcd_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   // Datapath operand mux selects
   localparam logic SEL_EXT = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   // States in which a run is in progress
   function automatic logic busy_state(input state_t s);
      return (s == LOAD) || (s == RUN) || (s == OUT);
   endfunction

endpackage

// File: rtl/gcd_control_if.sv
// Handshake and datapath-control bundle between the GCD controller and its surroundings.
interface gcd_control_if;

   logic start;
   logic x_lt_y;
   logic x_ne_y;
   logic x_sel;
   logic y_sel;
   logic x_en;
   logic y_en;
   logic output_en;
   logic busy;
   logic done;
   logic error;

   // System/datapath side
   modport master (
      output start, x_lt_y, x_ne_y,
      input  x_sel, y_sel, x_en, y_en, output_en, busy, done, error
   );

   // Controller side
   modport slave (
      input  start, x_lt_y, x_ne_y,
      output x_sel, y_sel, x_en, y_en, output_en, busy, done, error
   );

endinterface

// File: rtl/gcd_iter_counter.sv
// Saturating step counter with synchronous clear and terminal flag at MAX_ITER.
module gcd_iter_counter #(
   parameter int unsigned MAX_ITER = 1024,
   parameter int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_max_c
);

   assign at_max_c = (count == CNT_W'(MAX_ITER));

   // Clear wins over increment; increment stops at the terminal value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max_c) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/gcd_control.sv
// Control FSM for the subtractive GCD datapath with start/done handshake and
// an iteration limit that turns degenerate operands into an error exit.
// Optional macro GCD_ITER_COUNT_EN exposes the step counter as iter_count.
module gcd_control
   import gcd_pkg::*;
#(
   parameter  int unsigned MAX_ITER = 1024,
   localparam int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
   input  logic             clock,
   input  logic             reset,
   gcd_control_if.slave     bus
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [CNT_W-1:0] iter_count
`endif
);

   state_t state;
   state_t nxt_c;
   logic   load_q;
   logic   busy_q;
   logic   done_q;
   logic   error_q;
   logic   oen_q;
   logic   at_max_c;
   logic   run_c;
   logic   step_x_c;
   logic   step_y_c;

   // One subtraction step per RUN cycle while operands differ and budget remains
   assign run_c    = (state == RUN);
   assign step_y_c = run_c && bus.x_ne_y && !at_max_c &&  bus.x_lt_y;
   assign step_x_c = run_c && bus.x_ne_y && !at_max_c && !bus.x_lt_y;

   assign bus.x_en      = load_q | step_x_c;
   assign bus.y_en      = load_q | step_y_c;
   assign bus.x_sel     = step_x_c ? SEL_SUB : SEL_EXT;
   assign bus.y_sel     = step_y_c ? SEL_SUB : SEL_EXT;
   assign bus.output_en = oen_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;

   // Next-state decode; start is only honoured in IDLE, DONE and ERR
   always_comb begin
      nxt_c = state;
      case (state)
         IDLE:    if (bus.start) nxt_c = LOAD;
         LOAD:    nxt_c = RUN;
         RUN: begin
            if (!bus.x_ne_y)  nxt_c = OUT;
            else if (at_max_c) nxt_c = ERR;
         end
         OUT:     nxt_c = DONE;
         DONE:    if (bus.start) nxt_c = LOAD;
         ERR:     if (bus.start) nxt_c = LOAD;
         default: nxt_c = IDLE;
      endcase
   end

   // State register with Moore outputs registered from the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         oen_q   <= 1'b0;
      end else begin
         state   <= nxt_c;
         load_q  <= (nxt_c == LOAD);
         busy_q  <= busy_state(nxt_c);
         done_q  <= (nxt_c == DONE) || (nxt_c == ERR);
         error_q <= (nxt_c == ERR);
         oen_q   <= (nxt_c == OUT);
      end
   end

`ifdef GCD_ITER_COUNT_EN
   gcd_iter_counter #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .clr      (load_q),
      .inc      (step_x_c | step_y_c),
      .count    (iter_count),
      .at_max_c (at_max_c)
   );
`else
   logic [CNT_W-1:0] cnt_unused;

   gcd_iter_counter #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .clr      (load_q),
      .inc      (step_x_c | step_y_c),
      .count    (cnt_unused),
      .at_max_c (at_max_c)
   );
`endif

endmodule

// File: tb/tb_gcd_control.sv
// Scoreboard bench for gcd_control driving a small behavioural GCD datapath.
// Honours GCD_ITER_COUNT_EN when defined.
module tb_gcd_control;

   localparam int unsigned MAX_ITER = 16;
   localparam int unsigned CNT_W    = $clog2(MAX_ITER + 1);

   typedef struct {
      logic [7:0] out;
      bit         err;
      int         steps;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [7:0] ext_x, ext_y;
   logic [7:0] dx = 8'd0, dy = 8'd0, dout = 8'd0;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int run_start = 0;
   int steps  = 0;
   int oens   = 0;
   logic done_prev = 1'b0;
   exp_t sb[$];

   gcd_control_if bus ();

`ifdef GCD_ITER_COUNT_EN
   logic [CNT_W-1:0] iter_count;
`endif

   gcd_control #(.MAX_ITER(MAX_ITER)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
`ifdef GCD_ITER_COUNT_EN
      ,
      .iter_count (iter_count)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural datapath: operand registers, comparator flags, output register
   assign bus.x_lt_y = (dx < dy);
   assign bus.x_ne_y = (dx != dy);
   always @(posedge clk) begin
      if (bus.x_en)      dx   <= bus.x_sel ? dx - dy : ext_x;
      if (bus.y_en)      dy   <= bus.y_sel ? dy - dx : ext_y;
      if (bus.output_en) dout <= dx;
   end

   task automatic chk(input string name, input longint act, input longint req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [7:0] outs();
      return {bus.busy, bus.done, bus.error, bus.x_en, bus.y_en,
              bus.x_sel, bus.y_sel, bus.output_en};
   endfunction

   // Run bookkeeping at the active edge: start sampling and step/output_en counts
   always @(posedge clk) begin
      cyc++;
      if (bus.start && !bus.busy) begin
         run_start = cyc;
         steps     = 0;
         oens      = 0;
      end else begin
         steps += int'(bus.x_en && bus.x_sel) + int'(bus.y_en && bus.y_sel);
         oens  += int'(bus.output_en);
      end
   end

   // Monitor: on each rising done, pop the expected result and compare
   always @(negedge clk) begin
      if (bus.done && !done_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency", cyc - run_start + 1, e.lat);
            chk("error", bus.error, e.err);
            chk("steps", steps, e.steps);
            chk("output_en_pulses", oens, e.err ? 0 : 1);
            if (!e.err) chk("gcd_out", dout, e.out);
`ifdef GCD_ITER_COUNT_EN
            chk("iter_count", iter_count, e.steps);
`endif
         end
      end
      done_prev = bus.done;
   end

   // Pulse start from a negedge; returns at the negedge where LOAD is visible
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push,
                        input logic [7:0] o, input bit err, input int n, input int lat);
      if (push) sb.push_back('{out: o, err: err, steps: n, lat: lat});
      ext_x = a;
      ext_y = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("load_state", outs(), 8'b1001_1000);
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (!bus.done && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("done_reached", bus.done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      ext_x     = 8'd0;
      ext_y     = 8'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", outs(), 8'd0);
`ifdef GCD_ITER_COUNT_EN
      chk("reset_iter_count", iter_count, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // 12,8: two steps, gcd 4
      issue(8'd12, 8'd8, 1'b1, 8'd4, 1'b0, 2, 6);
      wait_done(100);
      @(negedge clk);
      chk("done_held", {bus.done, bus.error, bus.busy}, 3'b100);

      // 7,7 from DONE: no steps
      issue(8'd7, 8'd7, 1'b1, 8'd7, 1'b0, 0, 4);
      wait_done(100);

      // 0,5: never converges, 16 y steps then ERR
      issue(8'd0, 8'd5, 1'b1, 8'd0, 1'b1, 16, 19);
      wait_done(100);
      @(negedge clk);
      chk("err_held", {bus.done, bus.error, bus.output_en}, 3'b110);

      // 1,5 from ERR: error clears on LOAD, four y steps
      issue(8'd1, 8'd5, 1'b1, 8'd1, 1'b0, 4, 8);
      wait_done(100);

      // 21,14 with start pulses during RUN that must be ignored
      issue(8'd21, 8'd14, 1'b1, 8'd7, 1'b0, 2, 6);
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      wait_done(100);

      // 9,6 started straight from DONE
      issue(8'd9, 8'd6, 1'b1, 8'd3, 1'b0, 2, 6);
      wait_done(100);
      @(negedge clk);

      // Asynchronous reset in the middle of RUN
      issue(8'd12, 8'd8, 1'b0, 8'd0, 1'b0, 0, 0);
      @(negedge clk);
      chk("run_x_step", {bus.x_en, bus.x_sel, bus.y_en}, 3'b110);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", outs(), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", outs(), 8'd0);
`ifdef GCD_ITER_COUNT_EN
      chk("iter_count_after_reset", iter_count, 0);
`endif

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
